// File: rtl/msg_request_queue.sv
// Session message-request FIFO feeding the message composer one order at a time,
// with a request/done handshake and a watchdog against a composer that never finishes.
module msg_request_queue #(
  parameter int unsigned NUM_HOST       = 10,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      initiate_msg_i,
  input  logic [3:0]                create_message_i,
  input  logic [NUM_HOST-1:0]       host_i,
  input  logic                      busy_i,
  input  logic                      done_i,
  output logic                      start_o,
  output logic [3:0]                msg_type_o,
  output logic [NUM_HOST-1:0]       host_o,
  output logic [$clog2(DEPTH):0]    pending_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      drop_o,
  output logic                      overflow_o,
  output logic                      timeout_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = 16;

  typedef enum logic {IDLE, WAIT_DONE} state_e;

  typedef struct packed {
    logic [3:0]          mtype;
    logic [NUM_HOST-1:0] host;
  } req_t;

  state_e              state_q, state_d;
  req_t                mem_q [DEPTH];
  req_t                mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                start_q, start_d;
  logic [3:0]          msg_type_q, msg_type_d;
  logic [NUM_HOST-1:0] host_q, host_d;
  logic                drop_q, drop_d;
  logic                overflow_q, overflow_d;
  logic                timeout_q, timeout_d;

  logic empty_c, full_c, valid_type_c, push_req_c, push_c, pop_c;

  assign empty_c      = (count_q == CNT_W'(0));
  assign full_c       = (count_q == CNT_W'(DEPTH));
  assign valid_type_c = (create_message_i != 4'd0) && !create_message_i[3];
  assign push_req_c   = initiate_msg_i && valid_type_c;
  assign pop_c        = (state_q == IDLE) && !empty_c && !busy_i;
  assign push_c       = push_req_c && (!full_c || pop_c);

  // Next-state: FIFO bookkeeping, issue FSM and watchdog
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wdog_d     = wdog_q;
    msg_type_d = msg_type_q;
    host_d     = host_q;
    overflow_d = overflow_q;
    start_d    = 1'b0;
    drop_d     = 1'b0;
    timeout_d  = 1'b0;

    if (initiate_msg_i && create_message_i[3]) begin
      drop_d = 1'b1;
    end else if (push_req_c && !push_c) begin
      drop_d     = 1'b1;
      overflow_d = 1'b1;
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = '{mtype: create_message_i, host: host_i};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (pop_c) begin
          msg_type_d = mem_q[rd_ptr_q].mtype;
          host_d     = mem_q[rd_ptr_q].host;
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
          start_d    = 1'b1;
          wdog_d     = '0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // done_i during the start_o cycle belongs to no order and is ignored
        if (done_i && !start_q) begin
          state_d = IDLE;
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wdog_q     <= '0;
      start_q    <= 1'b0;
      msg_type_q <= '0;
      host_q     <= '0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wdog_q     <= wdog_d;
      start_q    <= start_d;
      msg_type_q <= msg_type_d;
      host_q     <= host_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign start_o    = start_q;
  assign msg_type_o = msg_type_q;
  assign host_o     = host_q;
  assign pending_o  = count_q;
  assign empty_o    = empty_c;
  assign full_o     = full_c;
  assign drop_o     = drop_q;
  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;

endmodule
